serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial unsigned adder with valid/ready handshakes on both sides.
// An operand pair is accepted in IDLE, added one bit per clock (LSB first)
// over WIDTH SHIFT cycles, and the result is then held in DONE until the
// downstream consumer takes it. Exactly one operation is in flight at a time.
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand pair a/b is presented
//   in_ready   block can accept an operand pair (IDLE only)
//   a, b       unsigned operands, WIDTH bits each
//   out_valid  sum/carry_out hold a completed result (DONE only)
//   out_ready  downstream consumes the result
//   sum        (a+b) mod 2^WIDTH, reads 0 whenever out_valid=0
//   carry_out  carry out of bit WIDTH-1, reads 0 whenever out_valid=0
//   busy       high in SHIFT or DONE
//
// WIDTH must be at least 2.
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    // Counter is one bit wider than strictly needed so the increment on the
    // final SHIFT edge never wraps.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    // -----------------------------------------------------------------------
    // One-bit full adder built from two half-adder stages plus an OR.
    // -----------------------------------------------------------------------
    logic ha1_sum;
    logic ha1_carry;
    logic ha2_sum;
    logic ha2_carry;
    logic bit_sum;
    logic carry_next;

    assign ha1_sum    = a_sh_reg[0] ^ b_sh_reg[0];
    assign ha1_carry  = a_sh_reg[0] & b_sh_reg[0];
    assign ha2_sum    = ha1_sum ^ carry_reg;
    assign ha2_carry  = ha1_sum & carry_reg;
    assign bit_sum    = ha2_sum;
    assign carry_next = ha1_carry | ha2_carry;

    // -----------------------------------------------------------------------
    // Next values of the shift registers for one SHIFT cycle. Operands move
    // right (zero fill); the result register takes each new sum bit at its
    // MSB, so after WIDTH cycles the first (LSB) sum bit has arrived at bit 0.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] a_sh_next;
    logic [WIDTH-1:0] b_sh_next;
    logic [WIDTH-1:0] res_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_sh_next[gi] = a_sh_reg[gi+1];
            assign b_sh_next[gi] = b_sh_reg[gi+1];
            assign res_next[gi]  = res_reg[gi+1];
        end
    endgenerate

    assign a_sh_next[WIDTH-1] = 1'b0;
    assign b_sh_next[WIDTH-1] = 1'b0;
    assign res_next[WIDTH-1]  = bit_sum;

    // The edge that processes bit WIDTH-1 is the last SHIFT edge.
    logic last_shift;
    assign last_shift = (cnt_reg == CW'(WIDTH - 1));

    // -----------------------------------------------------------------------
    // Control FSM and datapath registers. Status outputs are registered
    // alongside the state so in_ready never depends combinationally on any
    // input.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            res_reg       <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg     <= a;
                        b_sh_reg     <= b;
                        res_reg      <= '0;
                        carry_reg    <= 1'b0;
                        cnt_reg      <= '0;
                        state_reg    <= SHIFT;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end

                SHIFT: begin
                    a_sh_reg  <= a_sh_next;
                    b_sh_reg  <= b_sh_next;
                    res_reg   <= res_next;
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_shift) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end

                DONE: begin
                    // Result registers are frozen here; only the handshake
                    // moves us on. Clearing them leaves no stale result.
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        res_reg       <= '0;
                        carry_reg     <= 1'b0;
                        cnt_reg       <= '0;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    a_sh_reg      <= '0;
                    b_sh_reg      <= '0;
                    res_reg       <= '0;
                    carry_reg     <= 1'b0;
                    cnt_reg       <= '0;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. The partial result is masked during SHIFT so sum/carry_out
    // only ever show a completed value.
    // -----------------------------------------------------------------------
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign sum       = res_reg & {WIDTH{out_valid_reg}};
    assign carry_out = carry_reg & out_valid_reg;

endmodule
